// File: rtl/galaksija_tape_pkg.sv
// Shared state encoding and timing constants for the Galaksija cassette record/playback paths.
package galaksija_tape_pkg;

  typedef logic [1:0] tape_state_t;

  localparam tape_state_t ST_IDLE      = 2'd0;
  localparam tape_state_t ST_WAIT_MID  = 2'd1;
  localparam tape_state_t ST_WAIT_SYNC = 2'd2;

  // Decoder thresholds, all in ce ticks.
  localparam int unsigned TAPE_MIN_LOW      = 2;
  localparam int unsigned TAPE_MID_MAX      = 6900;
  localparam int unsigned TAPE_BIT_TIMEOUT  = 16000;
  localparam int unsigned TAPE_IDLE_TIMEOUT = 3072000;

  // Playback pulse spacing, shared with the tape player.
  localparam int unsigned TAPE_PLAY_STEP     = 1151;
  localparam int unsigned TAPE_PLAY_BYTE_GAP = 13000;

  // Bits arrive LSB first, so each new bit enters at the top of the byte.
  function automatic logic [7:0] shift_in(input logic b, input logic [7:0] sh);
    return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/galaksija_tape_pulse_det.sv
// Registers the cassette level and emits a one-cycle event when a low run reaches MIN_LOW ce ticks.
module galaksija_tape_pulse_det #(
  parameter int unsigned MIN_LOW = 2
) (
  input  logic cpuclk,
  input  logic reset,
  input  logic ce,
  input  logic lvl_in,
  output logic pulse
);

  localparam int unsigned RUN_W = $clog2(MIN_LOW + 1);

  logic             lvl_q, lvl_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             pulse_q, pulse_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lvl_d   = lvl_in;
    run_d   = run_q;
    pulse_d = 1'b0;
    if (lvl_q) begin
      run_d = '0;
    end else if (ce && (run_q != RUN_W'(MIN_LOW))) begin
      run_d   = run_q + RUN_W'(1);
      // Saturating at MIN_LOW keeps a long low run from producing a second event.
      pulse_d = (run_q == RUN_W'(MIN_LOW - 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      lvl_q   <= 1'b1;
      run_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/galaksija_tape_recorder.sv
// Cassette SAVE decoder: turns the CPU-driven pulse train into bytes written sequentially to a buffer.
module galaksija_tape_recorder
  import galaksija_tape_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned MIN_LOW      = TAPE_MIN_LOW,
  parameter int unsigned MID_MAX      = TAPE_MID_MAX,
  parameter int unsigned BIT_TIMEOUT  = TAPE_BIT_TIMEOUT,
  parameter int unsigned IDLE_TIMEOUT = TAPE_IDLE_TIMEOUT
) (
  input  logic              cpuclk,
  input  logic              reset,
  input  logic              ce,
  input  logic              arm,
  input  logic              tape_lvl,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W:0]   byte_count,
  output logic              recording,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic pulse;

  galaksija_tape_pulse_det #(
    .MIN_LOW (MIN_LOW)
  ) u_pulse_det (
    .cpuclk (cpuclk),
    .reset  (reset),
    .ce     (ce),
    .lvl_in (tape_lvl),
    .pulse  (pulse)
  );

  tape_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              arm_q, arm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic commit;
  logic commit_bit;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    arm_d        = arm;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    byte_count_d = byte_count_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    commit       = 1'b0;
    commit_bit   = 1'b0;

    if (pulse) begin
      cnt_d = '0;
    end else if (ce && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!arm) begin
      // Disarmed: drop any partial byte but keep the count and overflow for the upload.
      state_d  = ST_IDLE;
      bitcnt_d = '0;
    end else begin
      if (!arm_q) begin
        byte_count_d = '0;
        overflow_d   = 1'b0;
        bitcnt_d     = '0;
      end
      // A pulse is tested before either timeout, so it wins when both land together.
      case (state_q)
        ST_IDLE: begin
          if (pulse) state_d = ST_WAIT_MID;
        end
        ST_WAIT_MID: begin
          if (pulse) begin
            commit     = 1'b1;
            commit_bit = (cnt_q < CNT_W'(MID_MAX));
            state_d    = commit_bit ? ST_WAIT_SYNC : ST_WAIT_MID;
          end else if (cnt_q == CNT_W'(BIT_TIMEOUT)) begin
            commit  = 1'b1;
            state_d = ST_WAIT_SYNC;
          end
        end
        ST_WAIT_SYNC: begin
          if (pulse) begin
            state_d = ST_WAIT_MID;
          end else if (cnt_q == CNT_W'(IDLE_TIMEOUT)) begin
            bitcnt_d = '0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (commit) begin
      shreg_d  = shift_in(commit_bit, shreg_q);
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        if (byte_count_q == FULL_CNT) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_d      = 1'b1;
          wr_data_d    = shreg_d;
          wr_addr_d    = byte_count_q[ADDR_W-1:0];
          byte_count_d = byte_count_q + ONE_CNT;
        end
      end
    end
  end

  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      arm_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      arm_q        <= arm_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign byte_count = byte_count_q;
  assign recording  = (state_q != ST_IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_galaksija_tape_recorder.sv
// Directed bench for the cassette SAVE decoder, run with shortened timeouts and a 16-byte buffer.
module tb_galaksija_tape_recorder;

  localparam int ADDR_W       = 4;
  localparam int CNT_W        = 22;
  localparam int MIN_LOW      = 2;
  localparam int MID_MAX      = 69;
  localparam int BIT_TIMEOUT  = 160;
  localparam int IDLE_TIMEOUT = 3072;
  localparam int PER          = 96;   // bit cell, sync to sync
  localparam int MID          = 48;   // sync to mid-bit pulse for a '1'
  localparam int GAP          = 130;  // extra silence between bytes
  localparam int PW           = 3;    // low pulse width

  logic              cpuclk = 1'b0;
  logic              reset  = 1'b1;
  logic              ce     = 1'b1;
  logic              arm    = 1'b0;
  logic              tape_lvl = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   byte_count;
  logic              recording;
  logic              done;
  logic              overflow;

  galaksija_tape_recorder #(
    .ADDR_W       (ADDR_W),
    .CNT_W        (CNT_W),
    .MIN_LOW      (MIN_LOW),
    .MID_MAX      (MID_MAX),
    .BIT_TIMEOUT  (BIT_TIMEOUT),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .cpuclk     (cpuclk),
    .reset      (reset),
    .ce         (ce),
    .arm        (arm),
    .tape_lvl   (tape_lvl),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .byte_count (byte_count),
    .recording  (recording),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 cpuclk = ~cpuclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [7:0]        log_data[$];

  always @(posedge cpuclk) cyc <= cyc + 1;

  always @(negedge cpuclk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpuclk);
  endtask

  // Called on a negedge; leaves the line high again on a negedge w cycles later.
  task automatic low_pulse(input int w);
    tape_lvl  = 1'b0;
    last_fall = cyc;
    idle(w);
    tape_lvl  = 1'b1;
  endtask

  task automatic bit_cell(input logic b);
    low_pulse(PW);
    if (b) begin
      idle(MID - PW);
      low_pulse(PW);
      idle(PER - MID - PW);
    end else begin
      idle(PER - PW);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_cell(b[i]);
    idle(GAP);
  endtask

  task automatic rearm();
    arm = 1'b0;
    idle(4);
    arm = 1'b1;
    idle(4);
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    logic [7:0] v5a;
    logic [7:0] exp_b;
    int n_before;

    @(negedge cpuclk);
    idle(2);
    check("reset_outputs", {wr_en, wr_addr, wr_data, byte_count, recording, done, overflow}, 32'h0);
    reset = 1'b0;
    idle(4);

    // Two bytes in playback-style timing, then silence until the end-of-recording pulse.
    rearm();
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("t1_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t1_addr0", log_addr[0], 0);
      check("t1_data0", log_data[0], 8'hA5);
      check("t1_addr1", log_addr[1], 1);
      check("t1_data1", log_data[1], 8'h3C);
    end
    check("t1_byte_count", byte_count, 2);
    check("t1_recording", recording, 1);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge cpuclk);
    check("t1_done_seen", done_cnt, 1);
    // Input flop + MIN_LOW filter ticks + event flop, then IDLE_TIMEOUT+1 counts, then the done flop.
    check("t1_done_delay", done_cyc - last_fall, IDLE_TIMEOUT + MIN_LOW + 3);
    check("t1_recording_end", recording, 0);

    // All-zero byte: eight syncs, the last bit closed by the bit timeout.
    rearm();
    send_byte(8'h00);
    idle(100);
    check("t2_writes", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check("t2_addr", log_addr[0], 0);
      check("t2_data", log_data[0], 8'h00);
    end

    // Mid-bit threshold: falling-edge spacing s gives cnt = s-1 at the second event.
    rearm();
    low_pulse(PW);
    idle(MID_MAX - PW);          // cnt = MID_MAX-1 -> '1'
    low_pulse(PW);
    idle(PER - MID_MAX - PW);
    for (int i = 0; i < 7; i++) bit_cell(1'b0);
    idle(200);
    low_pulse(PW);
    idle(MID_MAX + 1 - PW);      // cnt = MID_MAX -> '0' and a new sync
    for (int i = 0; i < 7; i++) bit_cell(1'b0);
    idle(200);
    check("t3_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t3_below_mid", log_data[0], 8'h01);
      check("t3_at_mid", log_data[1], 8'h00);
    end

    // Short glitch inside a '0' bit, and a long ce stall between sync and mid pulse of a '1' bit.
    rearm();
    v5a = 8'h5A;
    low_pulse(PW);
    idle(27);
    low_pulse(MIN_LOW - 1);
    idle(PER - PW - 27 - (MIN_LOW - 1));
    low_pulse(PW);
    idle(20);
    ce = 1'b0;
    idle(10000);
    ce = 1'b1;
    idle(MID - PW - 20);
    low_pulse(PW);
    idle(PER - MID - PW);
    for (int i = 2; i < 8; i++) bit_cell(v5a[i]);
    idle(GAP + 100);
    check("t4_writes", log_addr.size(), 1);
    if (log_addr.size() == 1) check("t4_data", log_data[0], 8'h5A);

    // Fill the 16-byte buffer and push one more byte.
    rearm();
    for (int i = 0; i < 17; i++) send_byte(8'((i * 37 + 5) & 8'hFF));
    idle(100);
    check("t5_writes", log_addr.size(), 16);
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      exp_b = 8'((i * 37 + 5) & 8'hFF);
      check($sformatf("t5_addr%0d", i), log_addr[i], i);
      check($sformatf("t5_data%0d", i), log_data[i], exp_b);
    end
    check("t5_byte_count", byte_count, 16);
    check("t5_overflow", overflow, 1);
    arm = 1'b0;
    idle(4);
    check("t5_count_held", byte_count, 16);
    check("t5_overflow_held", overflow, 1);
    arm = 1'b1;
    idle(2);
    check("t5_count_cleared", byte_count, 0);
    check("t5_overflow_cleared", overflow, 0);

    // Reset in the middle of a byte.
    rearm();
    send_byte(8'h77);
    check("t6_pre_count", byte_count, 1);
    for (int i = 0; i < 5; i++) bit_cell(1'b1);
    low_pulse(PW);
    idle(20);
    n_before = log_addr.size();
    reset = 1'b1;
    idle(1);
    check("t6_reset_outputs", {wr_en, wr_addr, wr_data, byte_count, recording, done, overflow}, 32'h0);
    idle(3);
    reset = 1'b0;
    idle(300);
    check("t6_no_write", log_addr.size(), n_before);
    send_byte(8'hC3);
    idle(100);
    check("t6_writes", log_addr.size(), n_before + 1);
    if (log_addr.size() == n_before + 1) begin
      check("t6_addr", log_addr[n_before], 0);
      check("t6_data", log_data[n_before], 8'hC3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
